// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage: MEM pipeline stage between EX and WB.
//   Holds one instruction from EX, waits for the data-port response of a
//   memory access issued in EX, applies the load byte/half/unaligned merge and
//   hands a 170-bit bundle to WB. Responses that belong to instructions killed
//   by a WB flush are counted and dropped when they return.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   flush                 WB exception/eret/tlb refetch, kills the stage
//   ws_allowin            WB can accept
//   ms_allowin            this stage can accept
//   es_to_ms_valid/_bus   EX bundle {ld_op[7],mem_req,rt_value[32],wb_bundle[170]}
//   ms_to_ws_valid/_bus   WB bundle, result field replaced by the merged load data
//   data_sram_data_ok     data-port response strobe
//   data_sram_rdata       data-port read data, valid with data_ok
//   stall_ms_bus          {valid&|gr_we, gr_we&{4{valid}}, dest} for ID hazards
//   forward_ms_bus        {valid&ready_go, final result} for ID forwarding
//   ms_load_pending       valid load still waiting for data
//   ms_exc_eret_bus       {tlb_flush,exc,eret_flush} qualified by valid
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned ES_TO_MS_BUS_WD = 210,
    parameter int unsigned MS_TO_WS_BUS_WD = 170,
    parameter int unsigned CANCEL_W        = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [9:0]                 stall_ms_bus,
    output logic [32:0]                forward_ms_bus,
    output logic                       ms_load_pending,
    output logic [2:0]                 ms_exc_eret_bus
);

    // Field positions inside the EX bundle
    localparam int unsigned RES_LSB    = 32;
    localparam int unsigned RES_MSB    = RES_LSB + 31;
    localparam int unsigned DEST_LSB   = 64;
    localparam int unsigned GRWE_LSB   = 69;
    localparam int unsigned ERET_BIT   = 83;
    localparam int unsigned EXC_BIT    = 99;
    localparam int unsigned TLBF_BIT   = MS_TO_WS_BUS_WD - 1;
    localparam int unsigned RT_LSB     = MS_TO_WS_BUS_WD;
    localparam int unsigned MEMREQ_BIT = RT_LSB + 32;
    localparam int unsigned LDOP_LSB   = MEMREQ_BIT + 1;

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q, ms_bus_d;
    logic                       data_buf_valid_q, data_buf_valid_d;
    logic [31:0]                data_buf_q, data_buf_d;
    logic [CANCEL_W-1:0]        cancel_cnt_q, cancel_cnt_d;

    logic [6:0]  ld_op;
    logic        mem_req;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [1:0]  addr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;

    logic        cancel_idle;
    logic        resp_take;
    logic        ms_ready_go;
    logic        waiting;
    logic        cancel_inc;
    logic        cancel_dec;
    logic [31:0] mem_rdata;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] final_result;

    // Held bundle field decode
    assign ld_op      = ms_bus_q[LDOP_LSB +: 7];
    assign mem_req    = ms_bus_q[MEMREQ_BIT];
    assign rt_value   = ms_bus_q[RT_LSB +: 32];
    assign alu_result = ms_bus_q[RES_LSB +: 32];
    assign addr       = alu_result[1:0];
    assign gr_we      = ms_bus_q[GRWE_LSB +: 4];
    assign dest       = ms_bus_q[DEST_LSB +: 5];

    // A response belongs to the held instruction only when no killed
    // instruction still has a response in flight.
    assign cancel_idle = (cancel_cnt_q == '0);
    assign resp_take   = data_sram_data_ok && cancel_idle;
    assign ms_ready_go = !mem_req || data_buf_valid_q || resp_take;
    assign waiting     = ms_valid_q && mem_req && !data_buf_valid_q;

    // A response arriving in the flush cycle is the killed one's own, so it
    // only becomes a discard if nothing was taken for it this cycle.
    assign cancel_inc  = flush && waiting && !resp_take;
    assign cancel_dec  = data_sram_data_ok && !cancel_idle;

    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);

    // Next-state logic for stage contents, data buffer and discard counter
    always_comb begin
        ms_valid_d       = ms_valid_q;
        ms_bus_d         = ms_bus_q;
        data_buf_valid_d = data_buf_valid_q;
        data_buf_d       = data_buf_q;
        cancel_cnt_d     = cancel_cnt_q;

        if (cancel_inc && !cancel_dec) begin
            cancel_cnt_d = cancel_cnt_q + CANCEL_W'(1);
        end else if (cancel_dec && !cancel_inc) begin
            cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
        end

        if (flush) begin
            ms_valid_d       = 1'b0;
            data_buf_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d       = es_to_ms_valid;
            data_buf_valid_d = 1'b0;
            if (es_to_ms_valid) begin
                ms_bus_d = es_to_ms_bus;
            end
        end else if (waiting && resp_take) begin
            // Data arrived while WB is stalled: keep it for the transfer cycle
            data_buf_valid_d = 1'b1;
            data_buf_d       = data_sram_rdata;
        end
    end

    // Control state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q       <= 1'b0;
            data_buf_valid_q <= 1'b0;
            cancel_cnt_q     <= '0;
        end else begin
            ms_valid_q       <= ms_valid_d;
            data_buf_valid_q <= data_buf_valid_d;
            cancel_cnt_q     <= cancel_cnt_d;
        end
    end

    // Payload registers, only meaningful under their valid bits
    always_ff @(posedge clk) begin
        ms_bus_q   <= ms_bus_d;
        data_buf_q <= data_buf_d;
    end

    // Load merge
    assign mem_rdata = data_buf_valid_q ? data_buf_q : data_sram_rdata;

    always_comb begin
        byte_v       = 8'(mem_rdata >> {addr, 3'b000});
        half_v       = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        final_result = alu_result;
        if (ld_op[0]) begin
            final_result = {{24{byte_v[7]}}, byte_v};
        end else if (ld_op[1]) begin
            final_result = {24'd0, byte_v};
        end else if (ld_op[2]) begin
            final_result = {{16{half_v[15]}}, half_v};
        end else if (ld_op[3]) begin
            final_result = {16'd0, half_v};
        end else if (ld_op[4]) begin
            final_result = mem_rdata;
        end else if (ld_op[5]) begin
            case (addr)
                2'd0:    final_result = {mem_rdata[7:0],  rt_value[23:0]};
                2'd1:    final_result = {mem_rdata[15:0], rt_value[15:0]};
                2'd2:    final_result = {mem_rdata[23:0], rt_value[7:0]};
                default: final_result = mem_rdata;
            endcase
        end else if (ld_op[6]) begin
            case (addr)
                2'd0:    final_result = mem_rdata;
                2'd1:    final_result = {rt_value[31:24], mem_rdata[31:8]};
                2'd2:    final_result = {rt_value[31:16], mem_rdata[31:16]};
                default: final_result = {rt_value[31:8],  mem_rdata[31:24]};
            endcase
        end
    end

    assign ms_to_ws_bus    = {ms_bus_q[MS_TO_WS_BUS_WD-1:RES_MSB+1], final_result,
                              ms_bus_q[RES_LSB-1:0]};
    assign stall_ms_bus    = {ms_valid_q && (|gr_we), gr_we & {4{ms_valid_q}}, dest};
    assign forward_ms_bus  = {ms_to_ws_valid, final_result};
    assign ms_load_pending = ms_valid_q && (|ld_op) && !ms_ready_go;
    assign ms_exc_eret_bus = {ms_bus_q[TLBF_BIT], ms_bus_q[EXC_BIT], ms_bus_q[ERET_BIT]}
                             & {3{ms_valid_q}};

    // The discard counter must never wrap
    assert property (@(posedge clk) disable iff (!resetn)
                     !(cancel_inc && !cancel_dec && (&cancel_cnt_q)));

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: directed checks of the load merge, data buffering, discard and
// reset behaviour, followed by a randomized run against a transaction-level
// model (one held instruction, an in-order memory response queue with tags).
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [209:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [169:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;
    logic         ms_load_pending;
    logic [2:0]   ms_exc_eret_bus;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .stall_ms_bus      (stall_ms_bus),
        .forward_ms_bus    (forward_ms_bus),
        .ms_load_pending   (ms_load_pending),
        .ms_exc_eret_bus   (ms_exc_eret_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_LB  = 7'b0000001;
    localparam logic [6:0] OP_LBU = 7'b0000010;
    localparam logic [6:0] OP_LH  = 7'b0000100;
    localparam logic [6:0] OP_LW  = 7'b0010000;
    localparam logic [6:0] OP_LWL = 7'b0100000;
    localparam logic [6:0] OP_LWR = 7'b1000000;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state for the randomized phase
    typedef struct {
        int          tag;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t        memq[$];
    int           cyc     = 0;
    int           next_id = 0;
    bit           m_valid = 1'b0;
    bit           m_mem;
    bit           m_load;
    bit           m_arrived;
    int           m_id    = -1;
    logic [169:0] m_bus;
    logic [3:0]   m_gr_we;
    logic [4:0]   m_dest;
    logic [2:0]   m_exc3;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [169:0] rnd_wb();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[32*i +: 32] = $urandom;
        return t[169:0];
    endfunction

    function automatic logic [209:0] mk_es(input logic [6:0] op, input logic mreq,
                                           input logic [31:0] rt, input logic [169:0] wb,
                                           input logic [31:0] res);
        logic [169:0] w;
        w = wb;
        w[63:32] = res;
        return {op, mreq, rt, w};
    endfunction

    // Reference load merge written as shifts and masks on whole words
    function automatic logic [31:0] ref_merge(input logic [6:0] op, input logic [31:0] res,
                                              input logic [31:0] rt, input logic [31:0] d);
        int          a;
        logic [63:0] ones;
        logic [31:0] b;
        logic [31:0] h;
        a    = int'(res[1:0]);
        ones = 64'h0000_0000_FFFF_FFFF;
        b    = (d >> (8 * a)) & 32'hFF;
        h    = (d >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            7'b0000001: return b | (b[7]  ? 32'hFFFF_FF00 : 32'h0);
            7'b0000010: return b;
            7'b0000100: return h | (h[15] ? 32'hFFFF_0000 : 32'h0);
            7'b0001000: return h;
            7'b0010000: return d;
            7'b0100000: return 32'((64'(d) << (8 * (3 - a))) | (64'(rt) & (ones >> (8 * (a + 1)))));
            7'b1000000: return (d >> (8 * a)) | (rt & ~32'(ones >> (8 * a)));
            default:    return res;
        endcase
    endfunction

    // Load issued with an empty stage, response one cycle after accept
    task automatic load_now(input string tag, input logic [6:0] op, input logic [31:0] res,
                            input logic [31:0] rt, input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        es_to_ms_bus   = mk_es(op, 1'b1, rt, rnd_wb(), res);
        es_to_ms_valid = 1'b1;
        ws_allowin     = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        check({tag, "_pending"}, 192'(ms_load_pending), 192'(1));
        check({tag, "_wait"}, 192'(ms_to_ws_valid), 192'(0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        #1;
        check({tag, "_valid"}, 192'(ms_to_ws_valid), 192'(1));
        check({tag, "_res"}, 192'(ms_to_ws_bus[63:32]), 192'(exp));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    // One randomized cycle: drive, compare with the model, advance the model
    task automatic rand_cycle(input bit issue_en);
        int           killed;
        int           kind;
        int           due;
        bit           arr_now;
        bit           rdy;
        bit           exp_allow;
        logic [169:0] wb;
        logic [6:0]   op;
        logic         mreq;
        logic [31:0]  rt;
        logic [31:0]  res;
        logic [31:0]  rd;
        logic [31:0]  fres;

        @(negedge clk);
        killed = 0;
        foreach (memq[i]) if (!(m_valid && memq[i].tag == m_id)) killed++;
        flush          = issue_en && (killed <= 1) && ($urandom_range(0, 15) == 0);
        ws_allowin     = issue_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        es_to_ms_valid = issue_en && ($urandom_range(0, 2) != 0);
        kind = int'($urandom_range(0, 3));
        op   = 7'd0;
        mreq = (kind != 0);
        if (kind >= 2) op = 7'(1 << $urandom_range(0, 6));
        wb  = rnd_wb();
        rt  = $urandom;
        res = $urandom;
        rd  = $urandom;
        es_to_ms_bus      = mk_es(op, mreq, rt, wb, res);
        data_sram_data_ok = (memq.size() != 0) && (memq[0].due <= cyc);
        data_sram_rdata   = data_sram_data_ok ? memq[0].data : $urandom;
        #1;

        arr_now   = data_sram_data_ok && m_valid && m_mem && (memq[0].tag == m_id);
        rdy       = m_valid && (!m_mem || m_arrived || arr_now);
        exp_allow = !m_valid || (rdy && ws_allowin);
        check("r_allowin", 192'(ms_allowin), 192'(exp_allow));
        check("r_valid", 192'(ms_to_ws_valid), 192'(rdy));
        check("r_pending", 192'(ms_load_pending), 192'(m_valid && m_load && !rdy));
        check("r_stall_we", 192'(stall_ms_bus[9:5]),
              192'({m_valid && (|m_gr_we), m_gr_we & {4{m_valid}}}));
        check("r_exc", 192'(ms_exc_eret_bus), 192'(m_valid ? m_exc3 : 3'b000));
        check("r_fwd_v", 192'(forward_ms_bus[32]), 192'(rdy));
        if (m_valid) check("r_dest", 192'(stall_ms_bus[4:0]), 192'(m_dest));
        if (rdy) begin
            check("r_bus", 192'(ms_to_ws_bus), 192'(m_bus));
            check("r_fwd", 192'(forward_ms_bus[31:0]), 192'(m_bus[63:32]));
        end

        if (data_sram_data_ok) begin
            if (arr_now) m_arrived = 1'b1;
            void'(memq.pop_front());
        end
        if (flush) begin
            m_valid = 1'b0;
        end else begin
            if (rdy && ws_allowin) m_valid = 1'b0;
            if (es_to_ms_valid && exp_allow) begin
                next_id++;
                m_id      = next_id;
                m_valid   = 1'b1;
                m_mem     = mreq;
                m_load    = |op;
                m_arrived = 1'b0;
                fres      = (|op) ? ref_merge(op, res, rt, rd) : res;
                m_bus     = {wb[169:64], fres, wb[31:0]};
                m_gr_we   = wb[72:69];
                m_dest    = wb[68:64];
                m_exc3    = {wb[169], wb[99], wb[83]};
                if (mreq) begin
                    due = cyc + int'($urandom_range(1, 4));
                    if (memq.size() != 0 && memq[$].due >= due) due = memq[$].due + 1;
                    memq.push_back('{tag: m_id, data: rd, due: due});
                end
            end
        end
        cyc++;
    endtask

    initial begin
        logic [169:0] wb;
        logic [169:0] exp_wb;

        resetn = 1'b0; flush = 1'b0; ws_allowin = 1'b0; es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        #2;
        check("rst_valid", 192'(ms_to_ws_valid), 192'(0));
        check("rst_allowin", 192'(ms_allowin), 192'(1));
        check("rst_stall", 192'(stall_ms_bus[9:5]), 192'(0));
        check("rst_fwd_v", 192'(forward_ms_bus[32]), 192'(0));
        check("rst_pending", 192'(ms_load_pending), 192'(0));
        check("rst_exc", 192'(ms_exc_eret_bus), 192'(0));
        @(negedge clk);
        resetn = 1'b1;

        // ALU op passes through one cycle after accept
        @(negedge clk);
        wb = rnd_wb();
        wb[169] = 1'b1; wb[99] = 1'b1; wb[83] = 1'b0;
        wb[72:69] = 4'hF; wb[68:64] = 5'd5;
        es_to_ms_bus   = mk_es(7'd0, 1'b0, $urandom, wb, 32'h1234_5678);
        exp_wb         = es_to_ms_bus[169:0];
        es_to_ms_valid = 1'b1;
        ws_allowin     = 1'b1;
        #1;
        check("alu_allowin", 192'(ms_allowin), 192'(1));
        check("alu_not_yet", 192'(ms_to_ws_valid), 192'(0));
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        check("alu_valid", 192'(ms_to_ws_valid), 192'(1));
        check("alu_bus", 192'(ms_to_ws_bus), 192'(exp_wb));
        check("alu_stall", 192'(stall_ms_bus), 192'({1'b1, 4'hF, 5'd5}));
        check("alu_fwd", 192'(forward_ms_bus), 192'({1'b1, 32'h1234_5678}));
        check("alu_exc", 192'(ms_exc_eret_bus), 192'(3'b110));
        @(negedge clk);
        #1;
        check("alu_once", 192'(ms_to_ws_valid), 192'(0));

        // Load merge cases
        load_now("lb3",  OP_LB,  32'h0000_1003, 32'h0,         32'h80FF_FF12, 32'hFFFF_FF80);
        load_now("lbu3", OP_LBU, 32'h0000_1003, 32'h0,         32'h80FF_FF12, 32'h0000_0080);
        load_now("lh2",  OP_LH,  32'h0000_1002, 32'h0,         32'h80FF_FF12, 32'hFFFF_80FF);
        load_now("lwl1", OP_LWL, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        load_now("lwr2", OP_LWR, 32'h0000_2002, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);

        // Late data while WB stalls is buffered and delivered once
        @(negedge clk);
        es_to_ms_bus   = mk_es(OP_LW, 1'b1, $urandom, rnd_wb(), 32'h0000_0100);
        es_to_ms_valid = 1'b1;
        ws_allowin     = 1'b0;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1 check("buf_pend1", 192'(ms_load_pending), 192'(1));
        @(negedge clk);
        #1 check("buf_pend2", 192'(ms_load_pending), 192'(1));
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        check("buf_ok_valid", 192'(ms_to_ws_valid), 192'(1));
        check("buf_ok_allowin", 192'(ms_allowin), 192'(0));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BAD_0BAD;
        #1;
        check("buf_held_valid", 192'(ms_to_ws_valid), 192'(1));
        check("buf_held_res", 192'(ms_to_ws_bus[63:32]), 192'(32'hDEAD_BEEF));
        check("buf_held_pend", 192'(ms_load_pending), 192'(0));
        ws_allowin = 1'b1;
        #1 check("buf_release_allowin", 192'(ms_allowin), 192'(1));
        @(negedge clk);
        #1 check("buf_once", 192'(ms_to_ws_valid), 192'(0));

        // Flush while waiting: the killed load's response is dropped
        @(negedge clk);
        es_to_ms_bus   = mk_es(OP_LW, 1'b1, $urandom, rnd_wb(), 32'h0000_0200);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        flush          = 1'b1;
        @(negedge clk);
        flush          = 1'b0;
        es_to_ms_bus   = mk_es(OP_LW, 1'b1, $urandom, rnd_wb(), 32'h0000_0204);
        es_to_ms_valid = 1'b1;
        #1;
        check("fl_killed", 192'(ms_to_ws_valid), 192'(0));
        check("fl_allowin", 192'(ms_allowin), 192'(1));
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5757_5757;
        #1;
        check("fl_drop_valid", 192'(ms_to_ws_valid), 192'(0));
        check("fl_drop_pend", 192'(ms_load_pending), 192'(1));
        @(negedge clk);
        data_sram_rdata = 32'h600D_F00D;
        #1;
        check("fl_take_valid", 192'(ms_to_ws_valid), 192'(1));
        check("fl_take_res", 192'(ms_to_ws_bus[63:32]), 192'(32'h600D_F00D));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1 check("fl_once", 192'(ms_to_ws_valid), 192'(0));

        // Asynchronous reset with a pending load and an outstanding discard
        es_to_ms_bus   = mk_es(OP_LW, 1'b1, $urandom, rnd_wb(), 32'h0000_0300);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        flush          = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wb = rnd_wb();
        wb[169] = 1'b1;
        es_to_ms_bus   = mk_es(OP_LW, 1'b1, $urandom, wb, 32'h0000_0304);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        check("rp_pending", 192'(ms_load_pending), 192'(1));
        check("rp_exc", 192'(ms_exc_eret_bus[2]), 192'(1));
        #1 resetn = 1'b0;
        #1;
        check("rp_valid", 192'(ms_to_ws_valid), 192'(0));
        check("rp_pend0", 192'(ms_load_pending), 192'(0));
        check("rp_exc0", 192'(ms_exc_eret_bus), 192'(0));
        check("rp_stall0", 192'(stall_ms_bus[9:5]), 192'(0));
        check("rp_allowin", 192'(ms_allowin), 192'(1));
        @(negedge clk);
        resetn         = 1'b1;
        es_to_ms_bus   = mk_es(OP_LW, 1'b1, $urandom, rnd_wb(), 32'h0000_0308);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hC0FF_EE00;
        #1;
        check("rp_cnt_clear_valid", 192'(ms_to_ws_valid), 192'(1));
        check("rp_cnt_clear_res", 192'(ms_to_ws_bus[63:32]), 192'(32'hC0FF_EE00));
        @(negedge clk);
        data_sram_data_ok = 1'b0;

        // Randomized traffic against the model, then drain
        for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
        for (int i = 0; i < 40; i++) rand_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
